udp_tx_framer: RTL and testbench
================================

# udp_tx_framer

Transmit-side framer between the OutFIFO packet buffer and the UDP stack's transmit port. On a start command it emits one UDP header beat (destination IP, ports, UDP length). It then forwards exactly `length` payload bytes from the OutFIFO byte stream, forcing `tlast` on the final byte. It reports done or an error code back to the CSR block that issues the FIFO commands.

## Interface
Parameters:
- `MAX_PAYLOAD`, default 1472: largest legal payload length in bytes.
- `TIMEOUT_CYCLES`, default 1024: stall limit for the payload watchdog; used only under the configuration macro.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: one-cycle request to send a packet; sampled only in IDLE.
- `length_i` in 16: payload byte count.
- `dst_ip_i` in 32: destination IP address.
- `src_port_i` in 16: UDP source port.
- `dst_port_i` in 16: UDP destination port.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse when a packet completes cleanly.
- `err_o` out 1: one-cycle pulse on any error.
- `err_code_o` out 2: 0 none, 1 bad length, 2 early tlast, 3 timeout; sticky until the next accepted start.
- `s_tvalid` in 1, `s_tdata` in 8, `s_tlast` in 1, `s_tready` out 1: payload from the OutFIFO.
- `hdr_valid_o` out 1, `hdr_ready_i` in 1: header handshake.
- `hdr_ip_dst_o` out 32, `hdr_src_port_o` out 16, `hdr_dst_port_o` out 16, `hdr_length_o` out 16: header fields.
- `m_tvalid` out 1, `m_tdata` out 8, `m_tlast` out 1, `m_tready` in 1: payload to the UDP stack.

## Operation
- States: IDLE, HDR, PAYLOAD, DONE.
- **IDLE.** On `start_i`:
  - Clear `err_code_o`.
  - If `length_i == 0` or `length_i > MAX_PAYLOAD`: set code 1, pulse `err_o` next cycle, stay in IDLE.
  - Otherwise latch `length_i`, `dst_ip_i` and both ports into registers, then go to HDR.
- **HDR.**
  - Hold `hdr_valid_o` high.
  - `hdr_length_o` = latched length + 8, computed in 16 bits; no overflow is possible because of the length check.
  - On `hdr_valid_o && hdr_ready_i`, go to PAYLOAD with the beat counter at 0.
- **PAYLOAD.**
  - Combinational pass-through: `m_tvalid = s_tvalid`, `m_tdata = s_tdata`, `s_tready = m_tready`.
  - `m_tlast = (cnt == len-1) || s_tlast`.
  - On each handshake, `cnt` increments (16 bits).
  - Handshake with `cnt == len-1`: go to DONE. A late or absent `s_tlast` is ignored; the OutFIFO sees no more `s_tready`.
  - Handshake with `s_tlast` and `cnt < len-1`: early tlast. The beat is forwarded with `m_tlast=1`, code 2 is set, `err_o` pulses, and the FSM returns to IDLE.
- **DONE.** Pulse `done_o` for one cycle, then go to IDLE.
- Outside PAYLOAD: `s_tready=0`, `m_tvalid=0`, `m_tlast=0`.
- A `start_i` outside IDLE is ignored and not queued.

## Timing
- Reset values:
  - State IDLE.
  - `busy_o`, `done_o`, `err_o`, `hdr_valid_o`, `m_tvalid`, `m_tlast`, `s_tready` = 0.
  - `err_code_o` = 0.
  - Header field outputs = 0.
  - Counters = 0.
- Start to header:
  - `hdr_valid_o` rises the cycle after `start_i`.
  - Header fields are stable while `hdr_valid_o` is high.
  - `hdr_valid_o` is never dropped before `hdr_ready_i`.
- Payload has zero latency; throughput is 1 byte/cycle when both sides are ready.
- `done_o` is asserted the cycle after the last payload handshake.
- Minimum IDLE-to-IDLE time for length 1 with all readies high is 4 cycles: start, HDR, PAYLOAD, DONE.
- Bad-length `err_o` and early-tlast `err_o` both appear 1 cycle after the triggering event. `err_code_o` is valid in the same cycle as `err_o`.
- Asserting `rst` at any point returns to IDLE on the next edge with all outputs at reset values. It drops any in-flight header or payload with no `m_tlast` emitted.

## Configuration
- Macro: `UDP_TX_FRAMER_TIMEOUT_EN`.
- Defined:
  - A stall counter runs in PAYLOAD; it resets on every handshake and on state entry.
  - When the counter reaches `TIMEOUT_CYCLES`, the FSM aborts to IDLE, sets code 3 and pulses `err_o`. No further beat is emitted.
  - HDR is not watched.
- Undefined: no counter is built, PAYLOAD waits indefinitely, and code 3 never occurs.

## Test plan
- Start with length=4, dst_ip=0xC0A80102, ports 1234/5678, all readies high.
  - Header beat has length 12.
  - 4 bytes 0x10..0x13 with `m_tlast` on 0x13.
  - `done_o` pulses in cycle 7 after start.
- Length=0, then length=1473.
  - Each gives `err_o` with code 1 and no `hdr_valid_o`.
  - `busy_o` stays 0.
- Length=8 with `s_tlast` on byte 3.
  - Bytes 0..3 are forwarded and byte 3 has `m_tlast=1`.
  - Code 2, FSM back in IDLE, no `done_o`.
- Length=3, source never asserts `s_tlast`, and `m_tready` toggles 1010.
  - `m_tlast` on the 3rd handshake, `s_tready=0` afterwards, `done_o` pulses.
- `hdr_ready_i` held low for 20 cycles.
  - `hdr_valid_o` and the fields are stable throughout.
  - A second `start_i` issued during this period is ignored.
  - `rst` asserted mid-PAYLOAD gives IDLE with all outputs 0 the next cycle.
- With `UDP_TX_FRAMER_TIMEOUT_EN` and `TIMEOUT_CYCLES=16`: `s_tvalid` low for 16 cycles after 2 bytes gives code 3, `err_o` and a return to IDLE.

Source files
------------

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: sends one UDP header beat, then forwards exactly `length` payload bytes.
// Optional payload stall watchdog is built when UDP_TX_FRAMER_TIMEOUT_EN is defined. Rev 1.0
`default_nettype none

module udp_tx_framer #(
  parameter int MAX_PAYLOAD    = 1472,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] length_i,
  input  logic [31:0] dst_ip_i,
  input  logic [15:0] src_port_i,
  input  logic [15:0] dst_port_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  input  logic        s_tvalid,
  input  logic [7:0]  s_tdata,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic        hdr_valid_o,
  input  logic        hdr_ready_i,
  output logic [31:0] hdr_ip_dst_o,
  output logic [15:0] hdr_src_port_o,
  output logic [15:0] hdr_dst_port_o,
  output logic [15:0] hdr_length_o,
  output logic        m_tvalid,
  output logic [7:0]  m_tdata,
  output logic        m_tlast,
  input  logic        m_tready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  // Length + 8 must fit in 16 bits for the header length field.
  generate
    if (MAX_PAYLOAD < 1 || MAX_PAYLOAD > 65527 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("udp_tx_framer: MAX_PAYLOAD or TIMEOUT_CYCLES out of range");
    end
  endgenerate

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] hlen_q, hlen_d;
  logic [31:0] ip_q, ip_d;
  logic [15:0] sport_q, sport_d;
  logic [15:0] dport_q, dport_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic        hs;
  logic        last_beat;
  logic [15:0] len_m1;

  assign len_m1    = len_q - 16'd1;
  assign last_beat = (cnt_q == len_m1);
  assign hs        = (state_q == PAYLOAD) && s_tvalid && m_tready;

`ifdef UDP_TX_FRAMER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
  logic [STALL_W-1:0] stall_q, stall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      hlen_q  <= '0;
      ip_q    <= '0;
      sport_q <= '0;
      dport_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hlen_q  <= hlen_d;
      ip_q    <= ip_d;
      sport_q <= sport_d;
      dport_q <= dport_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    hlen_d   = hlen_q;
    ip_d     = ip_q;
    sport_d  = sport_q;
    dport_d  = dport_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    code_d   = code_q;
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = 8'd0;
    m_tlast  = 1'b0;
`ifdef UDP_TX_FRAMER_TIMEOUT_EN
    stall_d  = '0;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          code_d = 2'd0;
          if (length_i == 16'd0 || length_i > MAX_LEN) begin
            code_d = 2'd1;
            err_d  = 1'b1;
          end else begin
            len_d   = length_i;
            hlen_d  = length_i + 16'd8;
            ip_d    = dst_ip_i;
            sport_d = src_port_i;
            dport_d = dst_port_i;
            state_d = HDR;
          end
        end
      end

      HDR: begin
        cnt_d = 16'd0;
        if (hdr_ready_i) begin
          state_d = PAYLOAD;
        end
      end

      PAYLOAD: begin
        s_tready = m_tready;
        m_tvalid = s_tvalid;
        m_tdata  = s_tdata;
        m_tlast  = last_beat || s_tlast;
        if (hs) begin
          cnt_d = cnt_q + 16'd1;
          if (last_beat) begin
            state_d = DONE;
          end else if (s_tlast) begin
            code_d  = 2'd2;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
`ifdef UDP_TX_FRAMER_TIMEOUT_EN
        // Abort only on a cycle without a handshake, so no beat is lost mid-transfer.
        if (!hs) begin
          if (stall_q == STALL_LAST) begin
            code_d  = 2'd3;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign hdr_valid_o    = (state_q == HDR);
  assign err_o          = err_q;
  assign err_code_o     = code_q;
  assign hdr_ip_dst_o   = ip_q;
  assign hdr_src_port_o = sport_q;
  assign hdr_dst_port_o = dport_q;
  assign hdr_length_o   = hlen_q;

endmodule

`default_nettype wire

// File: tb/tb_udp_tx_framer.sv
// Testbench for udp_tx_framer: vector table plus header/payload scoreboards.
`timescale 1ns/1ps
`default_nettype none

module tb_udp_tx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] length_i;
  logic [31:0] dst_ip_i;
  logic [15:0] src_port_i;
  logic [15:0] dst_port_i;
  logic        busy_o, done_o, err_o;
  logic [1:0]  err_code_o;
  logic        s_tvalid, s_tlast, s_tready;
  logic [7:0]  s_tdata;
  logic        hdr_valid_o, hdr_ready_i;
  logic [31:0] hdr_ip_dst_o;
  logic [15:0] hdr_src_port_o, hdr_dst_port_o, hdr_length_o;
  logic        m_tvalid, m_tlast, m_tready;
  logic [7:0]  m_tdata;

  always #5 clk = ~clk;

  udp_tx_framer #(.MAX_PAYLOAD(1472), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .length_i(length_i),
    .dst_ip_i(dst_ip_i), .src_port_i(src_port_i), .dst_port_i(dst_port_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .hdr_valid_o(hdr_valid_o), .hdr_ready_i(hdr_ready_i),
    .hdr_ip_dst_o(hdr_ip_dst_o), .hdr_src_port_o(hdr_src_port_o),
    .hdr_dst_port_o(hdr_dst_port_o), .hdr_length_o(hdr_length_o),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready)
  );

  typedef struct {
    logic [15:0] len;
    logic [31:0] ip;
    logic [15:0] sp;
    logic [15:0] dp;
    int          tlast_at;
    bit          toggle;
    logic [1:0]  code;
    bit          done;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] len;
  } hdr_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  hdr_t  hdr_q[$];
  beat_t b_mon;
  hdr_t  h_mon;
  vec_t  vecs[8];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: sampled on the falling edge, between driving and the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (hdr_valid_o === 1'b1 && hdr_ready_i === 1'b1) begin
        if (hdr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL hdr_unexpected: got header beat length %0d, expected none", hdr_length_o);
        end else begin
          h_mon = hdr_q.pop_front();
          check("hdr_ip", 96'(hdr_ip_dst_o), 96'(h_mon.ip));
          check("hdr_ports", 96'({hdr_src_port_o, hdr_dst_port_o}), 96'({h_mon.sp, h_mon.dp}));
          check("hdr_length", 96'(hdr_length_o), 96'(h_mon.len));
        end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected: got data %0h last %0b, expected none", m_tdata, m_tlast);
        end else begin
          b_mon = exp_q.pop_front();
          check("beat_data_last", 96'({m_tdata, m_tlast}), 96'({b_mon.data, b_mon.last}));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start_i     = 1'b0;
    length_i    = 16'd0;
    dst_ip_i    = 32'd0;
    src_port_i  = 16'd0;
    dst_port_i  = 16'd0;
    s_tvalid    = 1'b0;
    s_tdata     = 8'd0;
    s_tlast     = 1'b0;
    m_tready    = 1'b1;
    hdr_ready_i = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    bit bad;
    int i;
    int cyc;
    bit ended;
    bit last;
    bad = (v.len == 16'd0) || (v.len > 16'd1472);
    start_i    = 1'b1;
    length_i   = v.len;
    dst_ip_i   = v.ip;
    src_port_i = v.sp;
    dst_port_i = v.dp;
    if (!bad) hdr_q.push_back('{ip: v.ip, sp: v.sp, dp: v.dp, len: v.len + 16'd8});
    tick;
    start_i = 1'b0;
    if (bad) begin
      check("badlen_err", 96'(err_o), 96'(1));
      check("badlen_code", 96'(err_code_o), 96'(v.code));
      check("badlen_hdr_valid", 96'(hdr_valid_o), 96'(0));
      check("badlen_busy", 96'(busy_o), 96'(0));
      tick;
      check("badlen_err_pulse", 96'(err_o), 96'(0));
      check("badlen_code_sticky", 96'(err_code_o), 96'(v.code));
      check("badlen_idle", 96'({busy_o, hdr_valid_o}), 96'(0));
      return;
    end
    check("start_hdr_valid", 96'({busy_o, hdr_valid_o}), 96'(2'b11));
    check("start_code_clear", 96'(err_code_o), 96'(0));
    tick;
    i = 0; cyc = 0; ended = 1'b0;
    while (!ended && cyc < 4 * int'(v.len) + 8) begin
      m_tready = v.toggle ? (cyc % 2 == 0) : 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = 8'(32'h10 + i);
      s_tlast  = (i == v.tlast_at);
      last     = (i == int'(v.len) - 1) || (i == v.tlast_at);
      if (m_tready) exp_q.push_back('{data: 8'(32'h10 + i), last: last});
      tick;
      cyc++;
      if (m_tready) begin
        if (last) ended = 1'b1;
        i++;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    check("payload_finished", 96'(ended), 96'(1));
    if (v.done) begin
      check("done_pulse", 96'({done_o, err_o, busy_o}), 96'(3'b101));
      check("done_s_tready", 96'(s_tready), 96'(0));
      check("done_code", 96'(err_code_o), 96'(0));
    end else begin
      check("early_err", 96'({done_o, err_o, busy_o}), 96'(3'b010));
      check("early_code", 96'(err_code_o), 96'(v.code));
    end
    tick;
    check("post_idle", 96'({done_o, err_o, busy_o}), 96'(0));
    check("beats_left", 96'(exp_q.size()), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'd4,    32'hC0A80102, 16'd1234, 16'd5678, 3,    1'b0, 2'd0, 1'b1};
    vecs[1] = '{16'd0,    32'h01020304, 16'd1,    16'd2,    -1,   1'b0, 2'd1, 1'b0};
    vecs[2] = '{16'd1473, 32'h01020304, 16'd1,    16'd2,    -1,   1'b0, 2'd1, 1'b0};
    vecs[3] = '{16'd8,    32'h0A0B0C0D, 16'd80,   16'd8080, 3,    1'b0, 2'd2, 1'b0};
    vecs[4] = '{16'd3,    32'hFFFFFFFE, 16'd7,    16'd9,    -1,   1'b1, 2'd0, 1'b1};
    vecs[5] = '{16'd1,    32'h11223344, 16'd53,   16'd54,   0,    1'b0, 2'd0, 1'b1};
    vecs[6] = '{16'd1472, 32'hAC100001, 16'd4000, 16'd4001, 1471, 1'b0, 2'd0, 1'b1};
    vecs[7] = '{16'd2,    32'h7F000001, 16'd10,   16'd11,   0,    1'b0, 2'd2, 1'b0};

    idle_inputs();
    rst = 1'b1;
    repeat (3) tick;
    check("reset_ctrl", 96'({busy_o, done_o, err_o, err_code_o, hdr_valid_o, m_tvalid, m_tlast, s_tready}), 96'(0));
    check("reset_hdr", 96'({hdr_ip_dst_o, hdr_src_port_o, hdr_dst_port_o, hdr_length_o}), 96'(0));
    rst = 1'b0;
    tick;

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Header back-pressure with an ignored second start, then reset mid-payload.
    start_i = 1'b1; length_i = 16'd2; dst_ip_i = 32'h0A000001;
    src_port_i = 16'd100; dst_port_i = 16'd200; hdr_ready_i = 1'b0;
    hdr_q.push_back('{ip: 32'h0A000001, sp: 16'd100, dp: 16'd200, len: 16'd10});
    tick;
    start_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("stall_hdr_valid", 96'(hdr_valid_o), 96'(1));
      check("stall_hdr_fields", 96'({hdr_ip_dst_o, hdr_src_port_o, hdr_dst_port_o, hdr_length_o}),
            96'({32'h0A000001, 16'd100, 16'd200, 16'd10}));
      start_i = (k == 5);
      length_i = 16'd7; dst_ip_i = 32'hDEADBEEF; src_port_i = 16'd1; dst_port_i = 16'd2;
      tick;
      start_i = 1'b0;
    end
    hdr_ready_i = 1'b1;
    tick;
    s_tvalid = 1'b1; s_tdata = 8'h55; s_tlast = 1'b0;
    exp_q.push_back('{data: 8'h55, last: 1'b0});
    tick;
    s_tvalid = 1'b0;
    rst = 1'b1;
    tick;
    check("midrst_ctrl", 96'({busy_o, done_o, err_o, err_code_o, hdr_valid_o, m_tvalid, m_tlast, s_tready}), 96'(0));
    check("midrst_hdr", 96'({hdr_ip_dst_o, hdr_src_port_o, hdr_dst_port_o, hdr_length_o}), 96'(0));
    rst = 1'b0;
    idle_inputs();
    tick;
    check("midrst_leftover", 96'(exp_q.size() + hdr_q.size()), 96'(0));
    run_vec(vecs[0]);

`ifdef UDP_TX_FRAMER_TIMEOUT_EN
    start_i = 1'b1; length_i = 16'd4; dst_ip_i = 32'h01010101;
    src_port_i = 16'd5; dst_port_i = 16'd6;
    hdr_q.push_back('{ip: 32'h01010101, sp: 16'd5, dp: 16'd6, len: 16'd12});
    tick;
    start_i = 1'b0;
    tick;
    for (int k = 0; k < 2; k++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'hA0 + k); s_tlast = 1'b0;
      exp_q.push_back('{data: 8'(8'hA0 + k), last: 1'b0});
      tick;
    end
    s_tvalid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick;
      if (k < 15) check("to_busy_waiting", 96'(busy_o), 96'(1));
    end
    check("to_err", 96'({err_o, err_code_o, busy_o, done_o}), 96'({1'b1, 2'd3, 1'b0, 1'b0}));
    tick;
    check("to_sticky", 96'({err_o, err_code_o}), 96'({1'b0, 2'd3}));
`endif

    check("final_queues", 96'(exp_q.size() + hdr_q.size()), 96'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
